// File: rtl/risc_pkg.sv
// Shared constants, opcode encoding and decoded-instruction layout for risc_cpu.
package risc_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NREGS     = 16;
  localparam int unsigned MEM_BYTES = 4096;
  localparam int unsigned AW        = 12;   // byte address width into memory
  localparam int unsigned RAW       = 4;    // register index width
  localparam int unsigned OPW       = 4;    // opcode width
  localparam int unsigned IMMW      = 16;

  // Instruction field positions (LSB of each field)
  localparam int unsigned OPC_LSB = 28;
  localparam int unsigned RD_LSB  = 24;
  localparam int unsigned RS1_LSB = 20;
  localparam int unsigned RS2_LSB = 16;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [OPW-1:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SLL  = 4'h6,
    OP_SRL  = 4'h7,
    OP_ADDI = 4'h8,
    OP_LUI  = 4'h9,
    OP_LW   = 4'hA,
    OP_SW   = 4'hB,
    OP_BEQ  = 4'hC,
    OP_BNE  = 4'hD,
    OP_JAL  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef struct packed {
    opcode_e           opc;
    logic [RAW-1:0]    rd;
    logic [RAW-1:0]    rs1;
    logic [RAW-1:0]    rs2;
    logic [IMMW-1:0]   imm;
  } instr_t;

  // Sign-extend the 16-bit immediate to XLEN
  function automatic logic [XLEN-1:0] sext_imm(input logic [IMMW-1:0] imm);
    return {{(XLEN-IMMW){imm[IMMW-1]}}, imm};
  endfunction

endpackage

// File: rtl/risc_memory.sv
// Unified 4 KiB byte memory: little-endian 32-bit fetch/data reads, 32-bit store.
module risc_memory
  import risc_pkg::*;
(
  input  logic            clk,
  input  logic [AW-1:0]   fetch_addr,
  output logic [XLEN-1:0] fetch_data_c,
  input  logic [AW-1:0]   data_addr,
  output logic [XLEN-1:0] rd_data_c,
  input  logic            we,
  input  logic [XLEN-1:0] wr_data
);

  logic [7:0] mem [0:MEM_BYTES-1];

  logic [AW-1:0] da1, da2, da3;

  // Little-endian word view; byte indices wrap inside the 12-bit space
  function automatic logic [XLEN-1:0] rd32(input logic [AW-1:0] a);
    return {mem[a + AW'(3)], mem[a + AW'(2)], mem[a + AW'(1)], mem[a]};
  endfunction

  // Wrapped byte addresses for the store
  always_comb begin
    da1 = data_addr + AW'(1);
    da2 = data_addr + AW'(2);
    da3 = data_addr + AW'(3);
  end

  assign fetch_data_c = rd32(fetch_addr);
  assign rd_data_c    = rd32(data_addr);

  // Store: four byte lanes written on the same edge
  always_ff @(posedge clk) begin
    if (we) begin
      mem[data_addr] <= wr_data[7:0];
      mem[da1]       <= wr_data[15:8];
      mem[da2]       <= wr_data[23:16];
      mem[da3]       <= wr_data[31:24];
    end
  end

endmodule

// File: rtl/risc_regfile.sv
// 16 x 32 register file: two combinational read ports, one write port, r0 hard zero.
module risc_regfile
  import risc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [RAW-1:0]  ra_addr,
  output logic [XLEN-1:0] ra_data_c,
  input  logic [RAW-1:0]  rb_addr,
  output logic [XLEN-1:0] rb_data_c,
  input  logic            we,
  input  logic [RAW-1:0]  wd_addr,
  input  logic [XLEN-1:0] wd_data
);

  logic [XLEN-1:0] r [0:NREGS-1];

  // Read ports; r0 reads zero regardless of array contents
  always_comb begin
    ra_data_c = (ra_addr == '0) ? '0 : r[ra_addr];
    rb_data_c = (rb_addr == '0) ? '0 : r[rb_addr];
  end

  // Write port; reset clears everything and wins over a pending write
  always_ff @(posedge clk) begin
    if (reset) begin
      r <= '{default: '0};
    end else if (we && (wd_addr != '0)) begin
      r[wd_addr] <= wd_data;
    end
  end

endmodule

// File: rtl/risc_cpu.sv
// Single-cycle 32-bit RISC core: PC, decode, ALU, next-PC; memory and regfile as sub-blocks.
module risc_cpu
  import risc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  output logic halted
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic [XLEN-1:0] fetch_word;
  instr_t          ins;
  logic [XLEN-1:0] simm;
  logic [RAW-1:0]  rb_addr;
  logic [XLEN-1:0] ra_val, rb_val;
  logic [AW-1:0]   data_addr;
  logic [XLEN-1:0] mem_rdata;
  logic [XLEN-1:0] pc_plus4, br_target;
  logic            rf_we, mem_we;
  logic [XLEN-1:0] rf_wdata;

  risc_memory memory1 (
    .clk          (clk),
    .fetch_addr   (AW'(pc_q)),
    .fetch_data_c (fetch_word),
    .data_addr    (data_addr),
    .rd_data_c    (mem_rdata),
    .we           (mem_we & ~reset),
    .wr_data      (rb_val)
  );

  risc_regfile register_file1 (
    .clk       (clk),
    .reset     (reset),
    .ra_addr   (ins.rs1),
    .ra_data_c (ra_val),
    .rb_addr   (rb_addr),
    .rb_data_c (rb_val),
    .we        (rf_we & ~reset),
    .wd_addr   (ins.rd),
    .wd_data   (rf_wdata)
  );

  // Field decode; SW/BEQ/BNE read rd through the second port instead of rs2
  always_comb begin
    ins.opc   = opcode_e'(fetch_word[OPC_LSB +: OPW]);
    ins.rd    = fetch_word[RD_LSB  +: RAW];
    ins.rs1   = fetch_word[RS1_LSB +: RAW];
    ins.rs2   = fetch_word[RS2_LSB +: RAW];
    ins.imm   = fetch_word[IMM_LSB +: IMMW];
    simm      = sext_imm(ins.imm);
    rb_addr   = ((ins.opc == OP_SW) || (ins.opc == OP_BEQ) || (ins.opc == OP_BNE))
                ? ins.rd : ins.rs2;
    data_addr = AW'(ra_val + simm);
    pc_plus4  = pc_q + XLEN'(4);
    br_target = pc_plus4 + {simm[XLEN-3:0], 2'b00};
  end

  // Execute: ALU result, register/memory write enables and next PC/state
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_plus4;
    rf_we    = 1'b0;
    rf_wdata = '0;
    mem_we   = 1'b0;
    if (state_q == ST_HALT) begin
      pc_d = pc_q;
    end else begin
      case (ins.opc)
        OP_NOP:  ;
        OP_ADD:  begin rf_we = 1'b1; rf_wdata = ra_val + rb_val;          end
        OP_SUB:  begin rf_we = 1'b1; rf_wdata = ra_val - rb_val;          end
        OP_AND:  begin rf_we = 1'b1; rf_wdata = ra_val & rb_val;          end
        OP_OR:   begin rf_we = 1'b1; rf_wdata = ra_val | rb_val;          end
        OP_XOR:  begin rf_we = 1'b1; rf_wdata = ra_val ^ rb_val;          end
        OP_SLL:  begin rf_we = 1'b1; rf_wdata = ra_val << rb_val[4:0];    end
        OP_SRL:  begin rf_we = 1'b1; rf_wdata = ra_val >> rb_val[4:0];    end
        OP_ADDI: begin rf_we = 1'b1; rf_wdata = ra_val + simm;            end
        OP_LUI:  begin rf_we = 1'b1; rf_wdata = {ins.imm, 16'h0000};      end
        OP_LW:   begin rf_we = 1'b1; rf_wdata = mem_rdata;                end
        OP_SW:   mem_we = 1'b1;
        OP_BEQ:  if (rb_val == ra_val) pc_d = br_target;
        OP_BNE:  if (rb_val != ra_val) pc_d = br_target;
        OP_JAL:  begin rf_we = 1'b1; rf_wdata = pc_plus4; pc_d = br_target; end
        OP_HALT: begin pc_d = pc_q; state_d = ST_HALT;                    end
      endcase
    end
  end

  // PC and run/halt state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_risc_cpu.sv
// Directed-program bench for risc_cpu with a queue-based scoreboard and a separate checker.
module tb_risc_cpu;

  localparam int K_REG  = 0;
  localparam int K_MEM  = 1;
  localparam int K_PC   = 2;
  localparam int K_HALT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic halted;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  event check_ev;

  always #5 clk = ~clk;

  risc_cpu dut (
    .clk    (clk),
    .reset  (reset),
    .halted (halted)
  );

  function automatic logic [31:0] enc(int op, int rd, int rs1, int rs2, int imm);
    return {4'(op), 4'(rd), 4'(rs1), 4'(rs2), 16'(imm)};
  endfunction

  function automatic logic [31:0] actual(int kind, int idx);
    case (kind)
      K_REG:   return dut.register_file1.r[4'(idx)];
      K_MEM:   return {24'h0, dut.memory1.mem[12'(idx)]};
      K_PC:    return dut.pc_q;
      default: return {31'h0, halted};
    endcase
  endfunction

  task automatic wr_word(int a, logic [31:0] w);
    for (int k = 0; k < 4; k++) dut.memory1.mem[12'(a + k)] = w[8*k +: 8];
  endtask

  task automatic expect_val(string n, int kind, int idx, logic [31:0] e);
    sb.push_back('{n, kind, idx, e});
  endtask

  task automatic do_check();
    ->check_ev;
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Hold reset across an edge so the core is parked while the program is loaded
  task automatic begin_test();
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_to_halt(string n);
    int cyc = 0;
    while (!halted && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!halted) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got running expected halted", n);
    end
  endtask

  // Checker: pops every queued expectation when the driver signals a sample point
  initial begin
    exp_t        e;
    logic [31:0] a;
    forever begin
      @(check_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        a = actual(e.kind, e.idx);
        checks++;
        if (a !== e.exp) begin
          failures++;
          $display("FAIL %s: got %08h expected %08h", e.name, a, e.exp);
        end
      end
    end
  end

  // Driver: load each program, run it, queue hand-computed results
  initial begin
    // Reset state
    @(posedge clk); #1;
    expect_val("rst_halted", K_HALT, 0, 32'h0);
    expect_val("rst_pc",     K_PC,   0, 32'h0);
    do_check();

    // ALU
    begin_test();
    wr_word(32'h00, enc(8, 1, 0, 0, 5));
    wr_word(32'h04, enc(8, 2, 0, 0, -3));
    wr_word(32'h08, enc(1, 3, 1, 2, 0));
    wr_word(32'h0C, enc(2, 4, 1, 2, 0));
    wr_word(32'h10, enc(5, 5, 1, 2, 0));
    wr_word(32'h14, enc(3, 6, 1, 2, 0));
    wr_word(32'h18, enc(4, 7, 1, 2, 0));
    wr_word(32'h1C, enc(6, 8, 2, 1, 0));
    wr_word(32'h20, enc(7, 9, 2, 1, 0));
    wr_word(32'h24, enc(15, 0, 0, 0, 0));
    release_reset();
    run_to_halt("alu");
    expect_val("alu_r1_addi",    K_REG, 1, 32'h0000_0005);
    expect_val("alu_r2_addi_neg", K_REG, 2, 32'hFFFF_FFFD);
    expect_val("alu_r3_add",     K_REG, 3, 32'h0000_0002);
    expect_val("alu_r4_sub",     K_REG, 4, 32'h0000_0008);
    expect_val("alu_r5_xor",     K_REG, 5, 32'hFFFF_FFF8);
    expect_val("alu_r6_and",     K_REG, 6, 32'h0000_0005);
    expect_val("alu_r7_or",      K_REG, 7, 32'hFFFF_FFFD);
    expect_val("alu_r8_sll",     K_REG, 8, 32'hFFFF_FFA0);
    expect_val("alu_r9_srl",     K_REG, 9, 32'h07FF_FFFF);
    expect_val("alu_halted",     K_HALT, 0, 32'h1);
    do_check();
    repeat (3) @(posedge clk);
    #1;
    expect_val("halt_pc_holds",  K_PC,  0, 32'h0000_0024);
    expect_val("halt_r1_holds",  K_REG, 1, 32'h0000_0005);
    do_check();

    // Memory round-trip
    begin_test();
    wr_word(32'h00, enc(9, 1, 0, 0, 16'hDEAD));
    wr_word(32'h04, enc(8, 1, 1, 0, 16'h00EF));
    wr_word(32'h08, enc(11, 1, 0, 0, 16'h0100));
    wr_word(32'h0C, enc(10, 6, 0, 0, 16'h0100));
    wr_word(32'h10, enc(15, 0, 0, 0, 0));
    release_reset();
    run_to_halt("mem");
    expect_val("mem_b100", K_MEM, 32'h100, 32'hEF);
    expect_val("mem_b101", K_MEM, 32'h101, 32'h00);
    expect_val("mem_b102", K_MEM, 32'h102, 32'hAD);
    expect_val("mem_b103", K_MEM, 32'h103, 32'hDE);
    expect_val("mem_r6_lw", K_REG, 6, 32'hDEAD_00EF);
    do_check();

    // Branch loop
    begin_test();
    wr_word(32'h00, enc(8, 1, 0, 0, 0));
    wr_word(32'h04, enc(8, 2, 0, 0, 10));
    wr_word(32'h08, enc(8, 1, 1, 0, 1));
    wr_word(32'h0C, enc(13, 1, 2, 0, -2));
    wr_word(32'h10, enc(15, 0, 0, 0, 0));
    release_reset();
    run_to_halt("loop");
    expect_val("loop_r1", K_REG, 1, 32'h0000_000A);
    expect_val("loop_pc", K_PC,  0, 32'h0000_0010);
    do_check();

    // JAL and r0
    begin_test();
    wr_word(32'h00, enc(0, 0, 0, 0, 0));
    wr_word(32'h04, enc(0, 0, 0, 0, 0));
    wr_word(32'h08, enc(14, 7, 0, 0, 1));
    wr_word(32'h0C, enc(8, 1, 0, 0, 1));
    wr_word(32'h10, enc(8, 0, 0, 0, 9));
    wr_word(32'h14, enc(15, 0, 0, 0, 0));
    release_reset();
    run_to_halt("jal");
    expect_val("jal_r7_link",  K_REG, 7, 32'h0000_000C);
    expect_val("jal_skipped",  K_REG, 1, 32'h0000_0000);
    expect_val("jal_r0_zero",  K_REG, 0, 32'h0000_0000);
    expect_val("jal_pc",       K_PC,  0, 32'h0000_0014);
    do_check();

    // Wrap-around store/load plus a taken BEQ
    begin_test();
    wr_word(32'h00, enc(9, 1, 0, 0, 16'h1122));
    wr_word(32'h04, enc(8, 1, 1, 0, 16'h3344));
    wr_word(32'h08, enc(8, 2, 0, 0, 16'h0FFE));
    wr_word(32'h0C, enc(11, 1, 2, 0, 0));
    wr_word(32'h10, enc(10, 3, 2, 0, 0));
    wr_word(32'h14, enc(12, 1, 3, 0, 1));
    wr_word(32'h18, enc(8, 4, 0, 0, 7));
    wr_word(32'h1C, enc(8, 5, 0, 0, 1));
    wr_word(32'h20, enc(15, 0, 0, 0, 0));
    release_reset();
    run_to_halt("wrap");
    expect_val("wrap_bFFE", K_MEM, 32'hFFE, 32'h44);
    expect_val("wrap_bFFF", K_MEM, 32'hFFF, 32'h33);
    expect_val("wrap_b000", K_MEM, 32'h000, 32'h22);
    expect_val("wrap_b001", K_MEM, 32'h001, 32'h11);
    expect_val("wrap_lw_r3", K_REG, 3, 32'h1122_3344);
    expect_val("beq_skip_r4", K_REG, 4, 32'h0000_0000);
    expect_val("beq_land_r5", K_REG, 5, 32'h0000_0001);
    do_check();

    // Reset mid-run of the loop, then let it restart and finish
    begin_test();
    wr_word(32'h00, enc(8, 1, 0, 0, 0));
    wr_word(32'h04, enc(8, 2, 0, 0, 10));
    wr_word(32'h08, enc(8, 1, 1, 0, 1));
    wr_word(32'h0C, enc(13, 1, 2, 0, -2));
    wr_word(32'h10, enc(15, 0, 0, 0, 0));
    release_reset();
    repeat (7) @(posedge clk);
    #1;
    expect_val("mid_r1_progress", K_REG, 1, 32'h0000_0003);
    do_check();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    expect_val("mid_rst_pc",     K_PC,   0, 32'h0);
    expect_val("mid_rst_r1",     K_REG,  1, 32'h0);
    expect_val("mid_rst_r2",     K_REG,  2, 32'h0);
    expect_val("mid_rst_halted", K_HALT, 0, 32'h0);
    expect_val("mid_mem_prog",   K_MEM,  3, 32'h81);
    expect_val("mid_mem_data",   K_MEM,  32'h100, 32'hEF);
    do_check();
    run_to_halt("restart");
    expect_val("restart_r1", K_REG, 1, 32'h0000_000A);
    expect_val("restart_pc", K_PC,  0, 32'h0000_0010);
    do_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
